// File: rtl/fp32_pair_packer.sv
// Packs a valid/ready stream of FP32 words into 64-bit pair beats, with optional
// denormal flush-to-zero and saturating NaN/Inf/denormal event counters.
module fp32_pair_packer #(
  parameter bit          FLUSH_DENORM = 1'b0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [1:0]       out_keep,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] nan_cnt,
  output logic [CNT_W-1:0] inf_cnt,
  output logic [CNT_W-1:0] denorm_cnt
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HALF = 1'b1
  } state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_low;
  logic                r_out_valid;
  logic [2*WORD_W-1:0] r_out_data;
  logic [1:0]          r_out_keep;
  logic [CNT_W-1:0]    r_nan_cnt;
  logic [CNT_W-1:0]    r_inf_cnt;
  logic [CNT_W-1:0]    r_denorm_cnt;

  logic [EXP_W-1:0]    w_exp;
  logic [MANT_W-1:0]   w_mant;
  logic                w_exp_ones;
  logic                w_exp_zero;
  logic                w_mant_nz;
  logic                w_is_nan;
  logic                w_is_inf;
  logic                w_is_denorm;
  logic [WORD_W-1:0]   w_lane;
  logic                w_accept;
  logic                w_beat_taken;
  logic [CNT_W-1:0]    w_cnt_max;

  // Classification always uses the raw input word, never the flushed lane.
  assign w_exp       = in_data[30:23];
  assign w_mant      = in_data[22:0];
  assign w_exp_ones  = (w_exp == {EXP_W{1'b1}});
  assign w_exp_zero  = (w_exp == {EXP_W{1'b0}});
  assign w_mant_nz   = (w_mant != {MANT_W{1'b0}});
  assign w_is_nan    = w_exp_ones && w_mant_nz;
  assign w_is_inf    = w_exp_ones && !w_mant_nz;
  assign w_is_denorm = w_exp_zero && w_mant_nz;

  assign w_lane = (FLUSH_DENORM && w_is_denorm) ? {in_data[31], {(WORD_W-1){1'b0}}} : in_data;

  assign in_ready     = !r_out_valid || out_ready;
  assign w_accept     = in_valid && in_ready;
  assign w_beat_taken = r_out_valid && out_ready;
  assign w_cnt_max    = {CNT_W{1'b1}};

  // Pairing FSM and output beat register; a fresh beat may load as the old one drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_low       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
    end else begin
      if (w_beat_taken) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (in_last) begin
              r_out_data  <= {{WORD_W{1'b0}}, w_lane};
              r_out_keep  <= 2'b01;
              r_out_valid <= 1'b1;
            end else begin
              r_low   <= w_lane;
              r_state <= S_HALF;
            end
          end
          S_HALF: begin
            r_out_data  <= {w_lane, r_low};
            r_out_keep  <= 2'b11;
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Saturating event counters; clear beats any same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_nan_cnt    <= '0;
      r_inf_cnt    <= '0;
      r_denorm_cnt <= '0;
    end else if (w_accept) begin
      if (w_is_nan && (r_nan_cnt != w_cnt_max)) begin
        r_nan_cnt <= r_nan_cnt + CNT_W'(1);
      end
      if (w_is_inf && (r_inf_cnt != w_cnt_max)) begin
        r_inf_cnt <= r_inf_cnt + CNT_W'(1);
      end
      if (w_is_denorm && (r_denorm_cnt != w_cnt_max)) begin
        r_denorm_cnt <= r_denorm_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_keep   = r_out_keep;
  assign nan_cnt    = r_nan_cnt;
  assign inf_cnt    = r_inf_cnt;
  assign denorm_cnt = r_denorm_cnt;

endmodule

// File: tb/tb_fp32_pair_packer.sv
// Directed bench for fp32_pair_packer: two instances share one stimulus stream,
// A = no flush with 2-bit counters, B = denormal flush with 16-bit counters.
module tb_fp32_pair_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;
  logic        cnt_clr;

  logic        a_in_ready, a_out_valid;
  logic [63:0] a_out_data;
  logic [1:0]  a_out_keep;
  logic [1:0]  a_nan, a_inf, a_den;

  logic        b_in_ready, b_out_valid;
  logic [63:0] b_out_data;
  logic [1:0]  b_out_keep;
  logic [15:0] b_nan, b_inf, b_den;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp32_pair_packer #(.FLUSH_DENORM(1'b0), .CNT_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .out_keep(a_out_keep),
    .cnt_clr(cnt_clr), .nan_cnt(a_nan), .inf_cnt(a_inf), .denorm_cnt(a_den)
  );

  fp32_pair_packer #(.FLUSH_DENORM(1'b1), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_keep(b_out_keep),
    .cnt_clr(cnt_clr), .nan_cnt(b_nan), .inf_cnt(b_inf), .denorm_cnt(b_den)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expect the same beat on both instances.
  task automatic chk_beat(input string tag, input logic v, input logic [63:0] d, input logic [1:0] k);
    chk({tag, "_a_valid"}, 64'(a_out_valid), 64'(v));
    chk({tag, "_b_valid"}, 64'(b_out_valid), 64'(v));
    if (v) begin
      chk({tag, "_a_data"}, a_out_data, d);
      chk({tag, "_b_data"}, b_out_data, d);
      chk({tag, "_a_keep"}, 64'(a_out_keep), 64'(k));
      chk({tag, "_b_keep"}, 64'(b_out_keep), 64'(k));
    end
  endtask

  task automatic push(input logic [31:0] w, input logic l);
    in_valid = 1'b1;
    in_data  = w;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    chk_beat("rst", 1'b0, 64'h0, 2'b00);
    chk("rst_a_data", a_out_data, 64'h0);
    chk("rst_b_keep", 64'(b_out_keep), 64'h0);
    chk("rst_a_ready", 64'(a_in_ready), 64'h1);
    chk("rst_b_ready", 64'(b_in_ready), 64'h1);
    chk("rst_a_nan", 64'(a_nan), 64'h0);
    chk("rst_b_den", 64'(b_den), 64'h0);

    // Four normal words, out_ready=1
    push(32'h3F80_0000, 1'b0);
    chk_beat("p1_half", 1'b0, 64'h0, 2'b00);
    push(32'h4000_0000, 1'b0);
    chk_beat("p1", 1'b1, 64'h4000_0000_3F80_0000, 2'b11);
    push(32'h4040_0000, 1'b0);
    chk_beat("p2_half", 1'b0, 64'h0, 2'b00);
    push(32'h4080_0000, 1'b0);
    chk_beat("p2", 1'b1, 64'h4080_0000_4040_0000, 2'b11);
    idle_cycle();
    chk_beat("p2_drain", 1'b0, 64'h0, 2'b00);

    // Single Inf with in_last from IDLE
    push(32'h7F80_0000, 1'b1);
    chk_beat("last", 1'b1, 64'h0000_0000_7F80_0000, 2'b01);
    chk("last_a_inf", 64'(a_inf), 64'h1);
    chk("last_b_inf", 64'(b_inf), 64'h1);
    idle_cycle();

    // Denormal pair: A passes bit-exact, B flushes to signed zero
    push(32'h8000_0001, 1'b0);
    push(32'h0040_0000, 1'b0);
    chk("den_a_data", a_out_data, 64'h0040_0000_8000_0001);
    chk("den_b_data", b_out_data, 64'h0000_0000_8000_0000);
    chk("den_a_keep", 64'(a_out_keep), 64'h3);
    chk("den_b_keep", 64'(b_out_keep), 64'h3);
    chk("den_a_cnt", 64'(a_den), 64'h2);
    chk("den_b_cnt", 64'(b_den), 64'h2);
    idle_cycle();

    // Backpressure: beat pending, Inf word held off for 5 cycles
    out_ready = 1'b0;
    push(32'h3F80_0000, 1'b0);
    push(32'h4000_0000, 1'b0);
    chk_beat("bp_load", 1'b1, 64'h4000_0000_3F80_0000, 2'b11);
    in_valid = 1'b1; in_data = 32'h7F80_0000; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_a_ready", 64'(a_in_ready), 64'h0);
      chk("bp_b_ready", 64'(b_in_ready), 64'h0);
      chk_beat("bp_hold", 1'b1, 64'h4000_0000_3F80_0000, 2'b11);
      chk("bp_a_inf", 64'(a_inf), 64'h1);
      chk("bp_b_inf", 64'(b_inf), 64'h1);
    end
    chk("bp_a_ready_rel", 64'(a_in_ready), 64'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_a_ready_comb", 64'(a_in_ready), 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_beat("bp_rel", 1'b0, 64'h0, 2'b00);
    chk("bp_a_inf2", 64'(a_inf), 64'h2);
    chk("bp_b_inf2", 64'(b_inf), 64'h2);
    push(32'h4080_0000, 1'b0);
    chk_beat("bp_b1", 1'b1, 64'h4080_0000_7F80_0000, 2'b11);
    push(32'h40A0_0000, 1'b0);
    chk_beat("bp_b2_half", 1'b0, 64'h0, 2'b00);
    push(32'h40C0_0000, 1'b0);
    chk_beat("bp_b2", 1'b1, 64'h40C0_0000_40A0_0000, 2'b11);
    idle_cycle();

    // NaN counting: A saturates at 3, B keeps counting
    for (int i = 0; i < 5; i++) begin
      push(32'h7FC0_0000, 1'b0);
      chk("nan_a_cnt", 64'(a_nan), (i < 3) ? 64'(i + 1) : 64'h3);
      chk("nan_b_cnt", 64'(b_nan), 64'(i + 1));
    end
    cnt_clr = 1'b1;
    push(32'h7FC0_0000, 1'b0);
    cnt_clr = 1'b0;
    chk_beat("nan_pair", 1'b1, 64'h7FC0_0000_7FC0_0000, 2'b11);
    chk("clr_a_nan", 64'(a_nan), 64'h0);
    chk("clr_b_nan", 64'(b_nan), 64'h0);
    chk("clr_a_inf", 64'(a_inf), 64'h0);
    chk("clr_b_den", 64'(b_den), 64'h0);
    idle_cycle();

    // Reset with a half pair held
    push(32'h3F80_0000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_beat("mid_rst", 1'b0, 64'h0, 2'b00);
    chk("mid_rst_a_ready", 64'(a_in_ready), 64'h1);
    push(32'h4000_0000, 1'b0);
    chk_beat("mid_rst_half", 1'b0, 64'h0, 2'b00);
    push(32'h4040_0000, 1'b0);
    chk_beat("mid_rst_pair", 1'b1, 64'h4040_0000_4000_0000, 2'b11);
    idle_cycle();

    // Reset with an unconsumed beat pending
    out_ready = 1'b0;
    push(32'h4080_0000, 1'b0);
    push(32'h40A0_0000, 1'b0);
    chk_beat("pend", 1'b1, 64'h40A0_0000_4080_0000, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("pend_rst_a_valid", 64'(a_out_valid), 64'h0);
    chk("pend_rst_a_data", a_out_data, 64'h0);
    chk("pend_rst_b_keep", 64'(b_out_keep), 64'h0);
    out_ready = 1'b1;
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
